gray_sequence_checker: RTL

GRAY_SEQUENCE_CHECKER -- requirements
Module: gray_sequence_checker

---
 rtl/gray_sequence_checker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gray_sequence_checker.sv
// Synchronizes an asynchronous Gray-code counter and converts it to binary.
// Flags +1 steps and invalid jumps. Define GRAY_CHECK_STALL_EN to add the stall timeout.
module gray_sequence_checker #(
    parameter int unsigned BITS           = 8,
    parameter int unsigned ERR_COUNT_BITS = 8,
    parameter int unsigned STALL_CYCLES   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BITS-1:0]           gray_in,
    output logic [BITS-1:0]           bin_out,
    output logic                      locked,
    output logic                      step,
    output logic                      error,
    output logic [ERR_COUNT_BITS-1:0] err_count,
    output logic                      stall
);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    if (STALL_CYCLES < 2 || STALL_CYCLES > (2 ** 24)) begin : g_bad_stall_cfg
        $error("STALL_CYCLES out of range 2..2^24");
    end

    logic [BITS-1:0]           r_s1;
    logic [BITS-1:0]           r_s2;
    logic [BITS-1:0]           r_s3;
    logic [0:0]                r_state;
    logic [BITS-1:0]           r_bin_out;
    logic                      r_step;
    logic                      r_error;
    logic [ERR_COUNT_BITS-1:0] r_err_count;

    logic                      w_change;
    logic [BITS-1:0]           w_bin;
    logic [BITS-1:0]           w_bin_inc;
    logic [0:0]                w_state_nxt;
    logic [BITS-1:0]           w_bin_nxt;
    logic                      w_step_nxt;
    logic                      w_error_nxt;
    logic [ERR_COUNT_BITS-1:0] w_err_count_nxt;

    function automatic logic [BITS-1:0] gray_to_bin(input logic [BITS-1:0] g);
        logic [BITS-1:0] b;
        b[BITS-1] = g[BITS-1];
        for (int i = int'(BITS) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_change  = (r_s2 != r_s3);
    assign w_bin     = gray_to_bin(r_s2);
    assign w_bin_inc = r_bin_out + BITS'(1);

    // Two-flop synchronizer plus one cycle of history for change detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= gray_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_UNLOCKED;
            r_bin_out   <= '0;
            r_step      <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bin_out   <= w_bin_nxt;
            r_step      <= w_step_nxt;
            r_error     <= w_error_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    // Any change other than +1 (mod 2^BITS) is an error; bin_out always resyncs
    always_comb begin
        w_state_nxt     = r_state;
        w_bin_nxt       = r_bin_out;
        w_step_nxt      = 1'b0;
        w_error_nxt     = 1'b0;
        w_err_count_nxt = r_err_count;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_change) begin
                    w_bin_nxt   = w_bin;
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_change) begin
                    w_bin_nxt = w_bin;
                    if (w_bin == w_bin_inc) begin
                        w_step_nxt = 1'b1;
                    end else begin
                        w_error_nxt = 1'b1;
                        if (r_err_count != '1) begin
                            w_err_count_nxt = r_err_count + ERR_COUNT_BITS'(1);
                        end
                    end
                end
            end
            default: w_state_nxt = ST_UNLOCKED;
        endcase
    end

    assign bin_out   = r_bin_out;
    assign locked    = r_state[0];
    assign step      = r_step;
    assign error     = r_error;
    assign err_count = r_err_count;

`ifdef GRAY_CHECK_STALL_EN
    localparam int unsigned STALL_W = $clog2(STALL_CYCLES);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES - 1);

    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_stall;

    // Counts quiet cycles while locked; saturates at STALL_MAX with stall held high
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_LOCKED || w_change) begin
            r_stall_cnt <= '0;
            r_stall     <= 1'b0;
        end else if (r_stall_cnt != STALL_MAX) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            r_stall     <= (r_stall_cnt == (STALL_MAX - STALL_W'(1)));
        end
    end

    assign stall = r_stall;
`else
    assign stall = 1'b0;
`endif

endmodule
